// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Shares the single MEM-stage data memory port between the pipeline
//   load/store unit (CPU) and a word-only loader/DMA port. Aligns addresses,
//   performs byte/half loads with sign/zero extension, and turns sub-word
//   stores into read-modify-write because the memory always writes 4 bytes.
//
// Ports
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   cpu_req/we/size/unsigned   : CPU request (size 00 byte, 01 half, 10 word)
//   cpu_addr, cpu_wdata        : CPU byte address, right-justified store data
//   cpu_gnt/done/rvalid/err    : CPU single-cycle status pulses
//   cpu_rdata                  : CPU extended load data (held until next load)
//   dma_req/we/addr/wdata      : DMA word request
//   dma_gnt/done/rvalid/err    : DMA status pulses, dma_rdata load data
//   mem_address/writeData      : word-aligned memory address, write data
//   mem_read, mem_write        : memory strobes (never both high)
//   mem_data_in                : combinational memory read data
module dmem_access_ctrl #(
  parameter int MEM_BYTES    = 128,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic        dma_rvalid,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data_in
);

  localparam int WCW = (DMA_MAX_WAIT < 1) ? 1 : $clog2(DMA_MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_RD, RMW_WR} state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;

  logic [31:0] addr_p1;
  logic [31:0] wdata_p1;
  logic [1:0]  size_p1;
  logic        we_p1;
  logic        uns_p1;
  logic        own_dma_p1;
  logic        err_p1;

  logic [31:0] merge_p2;
  logic [31:0] cpu_rdata_p2;
  logic [31:0] dma_rdata_p2;
  logic        cpu_rv_p2;
  logic        dma_rv_p2;

  logic        arb_any;
  logic        arb_dma;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_size;
  logic        sel_we;
  logic        sel_uns;
  logic        sel_bad;
  logic [31:0] load_val;

  function automatic logic [WCW-1:0] sat_inc(input logic [WCW-1:0] v);
    return (v == WCW'(DMA_MAX_WAIT)) ? v : v + WCW'(1);
  endfunction

  function automatic logic is_illegal(input logic [31:0] a, input logic [1:0] sz);
    logic bad;
    bad = (a > 32'(MEM_BYTES - 4));
    case (sz)
      2'b00:   bad = bad;
      2'b01:   bad = bad | a[0];
      2'b10:   bad = bad | (a[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Little-endian lane replacement of the read-back word.
  function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] lo, input logic [1:0] sz);
    logic [31:0] mask;
    logic [31:0] val;
    case (sz)
      2'b00: begin
        mask = 32'h0000_00FF << {lo, 3'b000};
        val  = {24'b0, wd[7:0]} << {lo, 3'b000};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {lo[1], 4'b0000};
        val  = {16'b0, wd[15:0]} << {lo[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        val  = wd;
      end
    endcase
    return (old & ~mask) | (val & mask);
  endfunction

  // Arbitration: CPU has priority until DMA has lost DMA_MAX_WAIT times in a row.
  always_comb begin
    arb_any   = cpu_req | dma_req;
    arb_dma   = dma_req & (~cpu_req | (wait_cnt == WCW'(DMA_MAX_WAIT)));
    sel_addr  = arb_dma ? dma_addr  : cpu_addr;
    sel_wdata = arb_dma ? dma_wdata : cpu_wdata;
    sel_we    = arb_dma ? dma_we    : cpu_we;
    sel_size  = arb_dma ? 2'b10     : cpu_size;
    sel_uns   = arb_dma ? 1'b0      : cpu_unsigned;
    sel_bad   = is_illegal(sel_addr, sel_size);
  end

  assign load_val = ext_load(mem_data_in, addr_p1[1:0], size_p1, uns_p1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      own_dma_p1   <= 1'b0;
      err_p1       <= 1'b0;
      cpu_rv_p2    <= 1'b0;
      dma_rv_p2    <= 1'b0;
      cpu_rdata_p2 <= '0;
      dma_rdata_p2 <= '0;
    end else begin
      cpu_rv_p2 <= 1'b0;
      dma_rv_p2 <= 1'b0;
      case (state)
        // p1: latch the winning request at acceptance
        IDLE: begin
          if (arb_any) begin
            addr_p1    <= sel_addr;
            wdata_p1   <= sel_wdata;
            size_p1    <= sel_size;
            we_p1      <= sel_we;
            uns_p1     <= sel_uns;
            own_dma_p1 <= arb_dma;
            err_p1     <= sel_bad;
            if (arb_dma)
              wait_cnt <= '0;
            else if (dma_req)
              wait_cnt <= sat_inc(wait_cnt);
            state <= (!sel_bad && sel_we && sel_size != 2'b10) ? RMW_RD : ACCESS;
          end
        end
        // p2: register extended load data for the owning requester
        ACCESS: begin
          if (!err_p1 && !we_p1) begin
            if (own_dma_p1) begin
              dma_rdata_p2 <= load_val;
              dma_rv_p2    <= 1'b1;
            end else begin
              cpu_rdata_p2 <= load_val;
              cpu_rv_p2    <= 1'b1;
            end
          end
          state <= IDLE;
        end
        // p2: capture the old word for the merge
        RMW_RD: begin
          merge_p2 <= mem_data_in;
          state    <= RMW_WR;
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held so an in-flight store is dropped.
  always_comb begin
    cpu_gnt       = 1'b0;
    dma_gnt       = 1'b0;
    cpu_done      = 1'b0;
    dma_done      = 1'b0;
    cpu_err       = 1'b0;
    dma_err       = 1'b0;
    cpu_rvalid    = 1'b0;
    dma_rvalid    = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    if (!reset) begin
      if (state != IDLE)
        mem_address = {addr_p1[31:2], 2'b00};
      case (state)
        IDLE: begin
          cpu_gnt = arb_any & ~arb_dma;
          dma_gnt = arb_dma;
        end
        ACCESS: begin
          if (err_p1) begin
            cpu_err  = ~own_dma_p1;
            dma_err  = own_dma_p1;
            cpu_done = ~own_dma_p1;
            dma_done = own_dma_p1;
          end else if (we_p1) begin
            mem_write     = 1'b1;
            mem_writeData = wdata_p1;
            cpu_done      = ~own_dma_p1;
            dma_done      = own_dma_p1;
          end else begin
            mem_read = 1'b1;
          end
        end
        RMW_RD: mem_read = 1'b1;
        RMW_WR: begin
          mem_write     = 1'b1;
          mem_writeData = merge_lane(merge_p2, wdata_p1, addr_p1[1:0], size_p1);
          cpu_done      = ~own_dma_p1;
          dma_done      = own_dma_p1;
        end
        default: mem_read = 1'b0;
      endcase
      cpu_rvalid = cpu_rv_p2;
      dma_rvalid = dma_rv_p2;
      cpu_done   = cpu_done | cpu_rv_p2;
      dma_done   = dma_done | dma_rv_p2;
    end
  end

  assign cpu_rdata = reset ? '0 : cpu_rdata_p2;
  assign dma_rdata = reset ? '0 : dma_rdata_p2;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: directed scenarios plus randomized CPU/DMA
// traffic. Expected responses come from a byte-array memory model and an
// arbitration loss counter, pushed into per-requester queues at each grant
// and popped by a monitor when the due cycle arrives.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;
  localparam int MEM_BYTES    = 128;
  localparam int DMA_MAX_WAIT = 4;
  localparam int AW           = $clog2(MEM_BYTES);
  localparam int NW           = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_unsigned;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_done, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_done, dma_rvalid, dma_err;
  logic [31:0] dma_rdata;
  logic [31:0] mem_address, mem_writeData, mem_data_in;
  logic        mem_read, mem_write;

  dmem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .DMA_MAX_WAIT(DMA_MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
    .dma_rdata(dma_rdata), .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  // Memory behind the controller; preload port used only during reset.
  logic [31:0] mem [0:NW-1];
  logic        pl_en;
  int          pl_idx;
  logic [31:0] pl_val;
  assign mem_data_in = mem[mem_address[AW-1:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_write) mem[mem_address[AW-1:2]] <= mem_writeData;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          err;
    bit          load;
    logic [31:0] rdata;
  } exp_t;

  exp_t       q_cpu[$];
  exp_t       q_dma[$];
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  int n_tests = 0;
  int n_fail  = 0;
  int losses  = 0;
  int cpu_run = 0;
  int last_run = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour of one accepted transaction.
  task automatic model(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int nb;
    bit bad;
    logic [31:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    bad = (sz == 2'd3) || (a > 32'(MEM_BYTES - 4)) || ((a % 32'(nb)) != 0);
    e.err = bad;
    e.load = !we;
    e.rdata = '0;
    if (bad) begin
      e.due = cyc + 1;
    end else if (!we) begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
      if (!uns && nb < 4 && v[8*nb-1])
        for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      e.rdata = v;
      e.due = cyc + 2;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      e.due = cyc + ((nb == 4) ? 1 : 2);
    end
  endtask

  task automatic done_check(input int r, input string nm, input logic done,
                            input logic rv, input logic er, input logic [31:0] rd);
    exp_t e;
    bit have;
    have = (r == 0) ? (q_cpu.size() > 0) : (q_dma.size() > 0);
    if (have) e = (r == 0) ? q_cpu[0] : q_dma[0];
    if (have && cyc >= e.due) begin
      if (r == 0) void'(q_cpu.pop_front()); else void'(q_dma.pop_front());
      chk({nm, "_done_at_due"}, 32'(done), 32'd1);
      chk({nm, "_err"}, 32'(er), 32'(e.err));
      chk({nm, "_rvalid"}, 32'(rv), 32'(e.load && !e.err));
      if (e.load && !e.err) chk({nm, "_rdata"}, rd, e.rdata);
      if (e.err) chk({nm, "_err_no_mem"}, 32'(mem_read | mem_write), 32'd0);
      else if (!e.load) chk({nm, "_store_mem_write"}, 32'(mem_write), 32'd1);
    end else if (done | rv | er) begin
      chk({nm, "_spurious"}, {29'b0, done, rv, er}, 32'd0);
    end
  endtask

  task automatic monitor();
    exp_t e;
    bit exp_dma;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
        done_check(0, "cpu", cpu_done, cpu_rvalid, cpu_err, cpu_rdata);
        done_check(1, "dma", dma_done, dma_rvalid, dma_err, dma_rdata);
        if (cpu_gnt | dma_gnt) begin
          exp_dma = dma_req && (!cpu_req || losses == DMA_MAX_WAIT);
          chk("arb_winner", 32'({cpu_gnt, dma_gnt}), exp_dma ? 32'd1 : 32'd2);
          if (dma_gnt) begin
            losses   = 0;
            last_run = cpu_run;
            cpu_run  = 0;
            model(dma_we, 2'b10, 1'b0, dma_addr, dma_wdata, e);
            q_dma.push_back(e);
          end else begin
            if (dma_req && losses < DMA_MAX_WAIT) losses++;
            cpu_run++;
            model(cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, e);
            q_cpu.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic cpu_go(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int t;
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_unsigned = uns;
    cpu_addr = a; cpu_wdata = wd;
    t = 0;
    do begin @(negedge clk); t++; end while (!cpu_gnt && t < 100);
    if (!cpu_gnt) chk("cpu_gnt_timeout", 32'(cpu_gnt), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic dma_go(input bit we, input logic [31:0] a, input logic [31:0] wd);
    int t;
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd;
    t = 0;
    do begin @(negedge clk); t++; end while (!dma_gnt && t < 100);
    if (!dma_gnt) chk("dma_gnt_timeout", 32'(dma_gnt), 32'd1);
    @(posedge clk); #1;
    dma_req = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q_cpu.size() != 0 || q_dma.size() != 0) && t < 200) begin
      @(negedge clk); t++;
    end
    chk("queue_drain", 32'(q_cpu.size() + q_dma.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic cpu_random(input int n);
    logic [1:0]  sz;
    logic [31:0] a;
    int nb;
    for (int k = 0; k < n; k++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a  = 32'($urandom_range(0, MEM_BYTES + 3));
      if ($urandom_range(0, 7) != 0) a = a & ~32'(nb - 1);
      cpu_go(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic dma_random(input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = 32'(4 * $urandom_range(0, NW - 1));
      if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(0, MEM_BYTES + 7));
      dma_go(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  snap [0:MEM_BYTES-1];
    logic [31:0] w;

    reset = 1'b1; pl_en = 1'b1; pl_idx = 0; pl_val = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_unsigned = 1'b0;
    cpu_addr = 32'd8; cpu_wdata = '0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'd12; dma_wdata = 32'h1234_5678;

    // Reset with both requests asserted while the memory is preloaded.
    for (int i = 0; i < NW; i++) begin
      pl_idx = i;
      pl_val = (i == 4) ? 32'h1122_3344 : $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = pl_val[8*b +: 8];
      @(negedge clk);
      chk("reset_ctrl_outputs",
          32'({cpu_gnt, cpu_done, cpu_rvalid, cpu_err, dma_gnt, dma_done, dma_rvalid,
               dma_err, mem_read, mem_write}), 32'd0);
      chk("reset_data_outputs", cpu_rdata | dma_rdata | mem_address | mem_writeData, 32'd0);
      @(posedge clk); #1;
    end
    pl_en = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    fork monitor(); join_none

    // Word round trip.
    cpu_go(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEAD_BEEF);
    wait_idle();
    cpu_go(1'b0, 2'b10, 1'b0, 32'd8, 32'd0);
    wait_idle();

    // Sub-word RMW then extended loads.
    cpu_go(1'b1, 2'b00, 1'b0, 32'd17, 32'h0000_00AA);
    wait_idle();
    cpu_go(1'b0, 2'b10, 1'b0, 32'd16, 32'd0);
    cpu_go(1'b0, 2'b00, 1'b0, 32'd17, 32'd0);
    cpu_go(1'b0, 2'b01, 1'b1, 32'd18, 32'd0);
    cpu_go(1'b0, 2'b01, 1'b0, 32'd18, 32'd0);
    wait_idle();

    // Illegal requests.
    cpu_go(1'b0, 2'b10, 1'b0, 32'd6, 32'd0);
    cpu_go(1'b1, 2'b01, 1'b0, 32'd3, 32'h5555);
    cpu_go(1'b0, 2'b10, 1'b0, 32'd126, 32'd0);
    cpu_go(1'b1, 2'b00, 1'b0, 32'd126, 32'h77);
    cpu_go(1'b1, 2'b11, 1'b0, 32'd20, 32'h1234_5678);
    wait_idle();

    // Starvation: back-to-back CPU loads against a waiting DMA store.
    cpu_run = 0; last_run = -1;
    fork
      for (int k = 0; k < 6; k++) cpu_go(1'b0, 2'b10, 1'b0, 32'(4 * $urandom_range(0, NW - 1)), 32'd0);
      dma_go(1'b1, 32'd40, 32'hCAFE_F00D);
    join
    wait_idle();
    chk("starve_cpu_wins_first", 32'(last_run), 32'd4);
    cpu_run = 0; last_run = -1;
    fork
      for (int k = 0; k < 6; k++) cpu_go(1'b0, 2'b00, 1'b1, 32'($urandom_range(0, MEM_BYTES - 4)), 32'd0);
      dma_go(1'b0, 32'd40, 32'd0);
    join
    wait_idle();
    chk("starve_cpu_wins_second", 32'(last_run), 32'd4);

    // Reset during RMW_RD of a byte store.
    for (int i = 0; i < MEM_BYTES; i++) snap[i] = ref_mem[i];
    cpu_go(1'b1, 2'b00, 1'b0, 32'd17, 32'h0000_0055);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rmw_no_done", 32'(cpu_done), 32'd0);
    chk("rst_rmw_no_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = snap[i];
    q_cpu.delete();
    losses = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_unsigned = 1'b0;
    cpu_addr = 32'd16; cpu_wdata = '0;
    @(negedge clk);
    chk("post_reset_gnt", 32'(cpu_gnt), 32'd1);
    chk("post_reset_no_done", 32'(cpu_done), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    wait_idle();

    // Randomized mixed traffic.
    fork
      cpu_random(80);
      dma_random(40);
    join
    wait_idle();

    // Final memory image against the model.
    for (int i = 0; i < NW; i++) begin
      for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[4*i + b];
      chk($sformatf("mem_word_%0d", i), mem[i], w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencing and arbitration controller in front of the MEM-stage data memory. It shares the single memory port between the pipeline load/store unit (requester CPU) and a word-only loader/DMA port (requester DMA). It aligns addresses and performs byte/halfword loads with sign or zero extension. Sub-word stores are done as read-modify-write, because the memory writes all four bytes on every store.

## Interface
- `MEM_BYTES`, 128: memory size in bytes; an access with `addr > MEM_BYTES-4` is out of range.
- `DMA_MAX_WAIT`, 4: number of consecutive lost arbitration cycles after which DMA wins.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU request; held with its fields stable until `cpu_done`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `cpu_unsigned` in 1: zero-extend loads when 1, sign-extend when 0.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-justified.
- `cpu_gnt` out 1: pulse in the acceptance cycle.
- `cpu_done` out 1: pulse when the CPU transaction completes.
- `cpu_rvalid` out 1: pulse with load data.
- `cpu_rdata` out 32: extended load data.
- `cpu_err` out 1: pulse for a misaligned, out-of-range or illegal-size request.
- `dma_req`, `dma_we`, `dma_addr[31:0]`, `dma_wdata[31:0]` in: DMA request. Word only, held until `dma_done`.
- `dma_gnt`, `dma_done`, `dma_rvalid`, `dma_err` out 1; `dma_rdata` out 32: same meaning as the CPU outputs.
- `mem_address` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_writeData` out 32, `mem_read` out 1, `mem_write` out 1: memory controls.
- `mem_data_in` in 32: combinational read data from the memory.

## Operation
- FSM states: IDLE, ACCESS, RMW_RD, RMW_WR.
- IDLE, arbitration:
  - If only one requester asserts req, it wins.
  - If both assert req, CPU wins unless `wait_cnt == DMA_MAX_WAIT`; in that case DMA wins.
- `wait_cnt`:
  - Increments, saturating, each IDLE cycle in which DMA requests and loses.
  - Clears when DMA is granted.
- The winner gets a `gnt` pulse in the IDLE cycle (combinational). addr, we, size, unsigned, wdata and the requester ID are latched at that edge.
- Legality is checked at acceptance:
  - Word requires `addr[1:0]==0`; half requires `addr[0]==0`.
  - size 11 is illegal.
  - Out of range per `MEM_BYTES` is illegal.
  - An illegal request goes to ACCESS with `err`+`done` pulsed there and no `mem_read`/`mem_write`.
- A legal request transitions:
  - Load or word store: IDLE→ACCESS.
  - Sub-word store: IDLE→RMW_RD.
- ACCESS, load:
  - `mem_read=1`.
  - Select lane `addr[1:0]` (byte) or `addr[1]` (half) from `mem_data_in`.
  - Extend the value and register it into `rdata`.
- ACCESS, word store: `mem_write=1`, `mem_writeData=wdata`.
- RMW_RD: `mem_read=1`; register `mem_data_in` into the merge buffer.
- RMW_WR:
  - `mem_write=1`.
  - `mem_writeData` = merge buffer with the target lane(s) replaced by `wdata[7:0]` (byte) or `wdata[15:0]` (half), little-endian.
- After ACCESS or RMW_WR the FSM always returns to IDLE. A new grant is possible in that IDLE cycle.
- `mem_read` and `mem_write` are never both 1. Both are 0 in IDLE.
- Reset in any state:
  - FSM→IDLE; latched request dropped; `wait_cnt=0`.
  - All outputs 0, including `rdata` registers and `mem_address`.
  - A store in flight during the reset cycle is not written.

## Timing
- Acceptance at cycle T; `gnt` is high in T.
- Load: `mem_read` in T+1; `rvalid`, `done` and `rdata` valid in T+2 (registered). `rdata` holds until the next load completes for that requester.
- Word store: `mem_write` in T+1; memory updates at the end of T+1; `done` in T+1.
- Sub-word store: RMW_RD in T+1, RMW_WR in T+2; `done` in T+2.
- Error: `err` and `done` in T+1.
- Peak throughput:
  - Loads: 1 per 2 cycles; the `rvalid` cycle overlaps the next IDLE.
  - Word stores: 1 per 2 cycles.
  - Sub-word stores: 1 per 3 cycles.
- `gnt`, `done`, `rvalid` and `err` are single-cycle pulses, and go only to the owning requester.

## Test plan
- Reset check: drive reset with `cpu_req=1` → `gnt` stays 0, and every output including `mem_*` is 0 while reset is held.
- Word round trip: CPU word store 0xDEADBEEF to addr 8, then a word load from 8.
  - Store: `mem_write` 1 cycle after grant, and `cpu_done` in the same cycle.
  - Load: `cpu_rvalid` 2 cycles after its grant, `cpu_rdata=0xDEADBEEF`.
- Sub-word RMW and extension: start with 0x11223344 at addr 16.
  - Byte store 0xAA at addr 17 → memory word 0x1122AA44; the store takes 3 cycles and `done` is at T+2.
  - Signed byte load from 17 → 0xFFFFFFAA.
  - Unsigned half load from 18 → 0x00001122.
- Errors: word load at addr 6, half store at addr 3, any access at addr 126 with `MEM_BYTES=128`, and size 11.
  - Each gives `cpu_err` and `cpu_done` at T+1.
  - None asserts `mem_read` or `mem_write`, and memory is unchanged.
- Arbitration and starvation: hold `cpu_req` (back-to-back loads) and `dma_req` together.
  - CPU wins 4 consecutive arbitrations.
  - DMA gets `dma_gnt` on the 5th arbitration; `wait_cnt` then restarts from 0.
  - DMA word store data reaches memory intact.
- Reset mid-RMW: assert reset during RMW_RD of a byte store → memory is unmodified, the FSM is back in IDLE, and no `done` pulse occurs. The next request is granted normally after reset deasserts.
